mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 51 +++++
 rtl/mem_arb.sv | 127 ++++++++++++
 tb/tb_mem_arb.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle for the fetch/load-store arbiter: two requester ports and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arb_if;
    // Every channel uses valid/ready: a beat transfers on a rising clk edge where
    // valid and ready are both 1; the payload is meaningful only while valid is 1.
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rdata;
    logic        if_flush;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_rsp_valid;
    logic        ls_rsp_ready;
    logic [31:0] ls_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, if_rsp_ready, if_flush,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wstrb, ls_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata,
        output ls_req_ready, ls_rsp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_rsp_ready
    );

    modport master (
        output if_req_valid, if_addr, if_rsp_ready, if_flush,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wstrb, ls_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata,
        input  ls_req_ready, ls_rsp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_rsp_ready
    );
endinterface

// File: rtl/mem_arb.sv
// Arbiter sharing one memory port between instruction fetch (IF) and load/store (LS),
// one transaction in flight, LS priority with an IF anti-starvation counter.
module mem_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    mem_arb_if.slave    bus,
    output logic [1:0]  dbg_state,
    output logic [2:0]  dbg_starve
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state, state_nxt;
    logic        owner_if, owner_if_nxt;
    logic        drop, drop_nxt;
    logic [2:0]  starve_cnt, starve_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic        wen_q, wen_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [3:0]  wstrb_q, wstrb_nxt;

    logic if_ok, grant_if, grant_ls, rsp_phase, rsp_ready_int;

    // Response handshake toward memory; a dropped fetch response is sunk unconditionally.
    assign rsp_phase     = rst && (state == RSP);
    assign rsp_ready_int = rsp_phase &&
                           (drop || (owner_if ? bus.if_rsp_ready : bus.ls_rsp_ready));

    always_comb begin
        state_nxt    = state;
        owner_if_nxt = owner_if;
        drop_nxt     = drop;
        starve_nxt   = starve_cnt;
        addr_nxt     = addr_q;
        wen_nxt      = wen_q;
        wdata_nxt    = wdata_q;
        wstrb_nxt    = wstrb_q;
        if_ok        = bus.if_req_valid && !bus.if_flush;
        grant_if     = 1'b0;
        grant_ls     = 1'b0;
        case (state)
            IDLE: begin
                grant_if = if_ok && (!bus.ls_req_valid || (starve_cnt == LIMIT));
                grant_ls = bus.ls_req_valid && !grant_if;
                if (grant_if) begin
                    state_nxt    = REQ;
                    owner_if_nxt = 1'b1;
                    addr_nxt     = bus.if_addr;
                    wen_nxt      = 1'b0;
                    wdata_nxt    = 32'h0;
                    wstrb_nxt    = 4'h0;
                    starve_nxt   = 3'd0;
                end else if (grant_ls) begin
                    state_nxt    = REQ;
                    owner_if_nxt = 1'b0;
                    addr_nxt     = bus.ls_addr;
                    wen_nxt      = bus.ls_wen;
                    wdata_nxt    = bus.ls_wdata;
                    wstrb_nxt    = bus.ls_wstrb;
                    // A flushed fetch neither ages nor resets the counter.
                    if (if_ok)
                        starve_nxt = (starve_cnt == LIMIT) ? LIMIT : 3'(starve_cnt + 3'd1);
                    else if (!bus.if_req_valid)
                        starve_nxt = 3'd0;
                end
            end
            REQ: begin
                if (bus.if_flush && owner_if) drop_nxt = 1'b1;
                if (bus.mem_req_ready) state_nxt = RSP;
            end
            RSP: begin
                if (bus.if_flush && owner_if) drop_nxt = 1'b1;
                if (bus.mem_rsp_valid && rsp_ready_int) begin
                    state_nxt = IDLE;
                    drop_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= 3'd0;
            addr_q     <= 32'h0;
            wen_q      <= 1'b0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
        end else begin
            state      <= state_nxt;
            owner_if   <= owner_if_nxt;
            drop       <= drop_nxt;
            starve_cnt <= starve_nxt;
            addr_q     <= addr_nxt;
            wen_q      <= wen_nxt;
            wdata_q    <= wdata_nxt;
            wstrb_q    <= wstrb_nxt;
        end
    end

    // Valid/ready outputs are forced low while reset is held.
    assign bus.if_req_ready  = rst && grant_if;
    assign bus.ls_req_ready  = rst && grant_ls;
    assign bus.mem_req_valid = rst && (state == REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wstrb     = wstrb_q;
    assign bus.mem_rsp_ready = rsp_ready_int;
    assign bus.if_rsp_valid  = rsp_phase && owner_if && !drop && bus.mem_rsp_valid;
    assign bus.ls_rsp_valid  = rsp_phase && !owner_if && bus.mem_rsp_valid;
    assign bus.if_rdata      = bus.mem_rdata;
    assign bus.ls_rdata      = bus.mem_rdata;

    assign dbg_state  = state;
    assign dbg_starve = starve_cnt;
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus a randomized transaction loop
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arb;
    localparam int STARVE_LIMIT = 4;
    localparam int W = 69;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [2:0] dbg_starve;
    int         total;
    int         bad;
    logic [W-1:0] exp_q[$];

    mem_arb_if bus ();

    mem_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_starve (dbg_starve)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_addr       = 32'h0;
        bus.if_rsp_ready  = 1'b0;
        bus.if_flush      = 1'b0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = 32'h0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = 32'h0;
        bus.ls_wstrb      = 4'h0;
        bus.ls_rsp_ready  = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;
    endtask

    // Drives a granted transaction from REQ through a one-cycle response back to IDLE.
    task automatic run_mem(input logic [31:0] rdata);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rdata;
        bus.if_rsp_ready  = 1'b1;
        bus.ls_rsp_ready  = 1'b1;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.if_rsp_ready  = 1'b0;
        bus.ls_rsp_ready  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bus.if_req_valid  = 1'b1;
        bus.ls_req_valid  = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        tick();
        tick();
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        total++; if (dbg_starve !== 3'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", dbg_starve); end
        total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b exp=0", bus.mem_req_valid); end
        total++; if (bus.mem_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_mem_rsp_ready got=%b exp=0", bus.mem_rsp_ready); end
        total++; if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b%b exp=00", bus.if_rsp_valid, bus.ls_rsp_valid); end
        total++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b%b exp=00", bus.if_req_ready, bus.ls_req_ready); end
        total++; if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb} !== 69'h0) begin bad++; $display("FAIL reset_payload got=%h exp=0", {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb}); end
        clear_inputs();
        rst = 1'b1;
        tick();
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL post_reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_if_alone();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0000;
        #1;
        total++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b10) begin bad++; $display("FAIL if_alone_grant got=%b%b exp=10", bus.if_req_ready, bus.ls_req_ready); end
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL if_alone_mem_req_valid got=%b exp=1", bus.mem_req_valid); end
        total++; if (bus.mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL if_alone_addr got=%h exp=80000000", bus.mem_addr); end
        total++; if ({bus.mem_wen, bus.mem_wstrb, bus.mem_wdata} !== 37'h0) begin bad++; $display("FAIL if_alone_wfields got=%b/%h/%h exp=0/0/0", bus.mem_wen, bus.mem_wstrb, bus.mem_wdata); end
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        total++; if (bus.if_rsp_valid !== 1'b0) begin bad++; $display("FAIL if_alone_early_rsp got=%b exp=0", bus.if_rsp_valid); end
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0413;
        bus.if_rsp_ready  = 1'b1;
        #1;
        total++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rdata !== 32'h0000_0413) begin bad++; $display("FAIL if_alone_rsp got=%b/%h exp=1/00000413", bus.if_rsp_valid, bus.if_rdata); end
        total++; if (bus.ls_rsp_valid !== 1'b0) begin bad++; $display("FAIL if_alone_ls_rsp got=%b exp=0", bus.ls_rsp_valid); end
        total++; if (bus.mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL if_alone_mem_rsp_ready got=%b exp=1", bus.mem_rsp_ready); end
        tick();
        clear_inputs();
        #1;
        total++; if (dbg_state !== ST_IDLE || bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL if_alone_back_idle got=%0d/%b exp=%0d/0", dbg_state, bus.mem_req_valid, ST_IDLE); end
    endtask

    task automatic test_ls_priority();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0040;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h8000_1000;
        bus.ls_wen       = 1'b1;
        bus.ls_wdata     = 32'hDEAD_BEEF;
        bus.ls_wstrb     = 4'hF;
        #1;
        total++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b01) begin bad++; $display("FAIL prio_grant got=%b%b exp=01", bus.if_req_ready, bus.ls_req_ready); end
        tick();
        bus.ls_req_valid = 1'b0;
        #1;
        total++; if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb} !== {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin bad++; $display("FAIL prio_ls_payload got=%h/%b/%h/%h exp=80001000/1/deadbeef/f", bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb); end
        total++; if (bus.if_req_ready !== 1'b0) begin bad++; $display("FAIL prio_if_ready_in_req got=%b exp=0", bus.if_req_ready); end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1234_5678;
        bus.ls_rsp_ready  = 1'b1;
        #1;
        total++; if ({bus.ls_rsp_valid, bus.if_rsp_valid} !== 2'b10) begin bad++; $display("FAIL prio_ls_rsp got=%b%b exp=10", bus.ls_rsp_valid, bus.if_rsp_valid); end
        total++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b00) begin bad++; $display("FAIL prio_no_grant_on_return got=%b%b exp=00", bus.if_req_ready, bus.ls_req_ready); end
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.ls_rsp_ready  = 1'b0;
        #1;
        total++; if (bus.if_req_ready !== 1'b1) begin bad++; $display("FAIL prio_if_next got=%b exp=1", bus.if_req_ready); end
        tick();
        bus.if_req_valid  = 1'b0;
        #1;
        total++; if (bus.mem_addr !== 32'h8000_0040 || bus.mem_wen !== 1'b0) begin bad++; $display("FAIL prio_if_payload got=%h/%b exp=80000040/0", bus.mem_addr, bus.mem_wen); end
        run_mem(32'h0000_0013);
    endtask

    task automatic test_flush_in_req();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0100;
        tick();
        bus.if_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            bus.if_flush = (c == 2);
            #1;
            total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0100) begin bad++; $display("FAIL flush_req_stable c=%0d got=%b/%h exp=1/80000100", c, bus.mem_req_valid, bus.mem_addr); end
            tick();
        end
        bus.if_flush      = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0100) begin bad++; $display("FAIL flush_req_accept got=%b/%h exp=1/80000100", bus.mem_req_valid, bus.mem_addr); end
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        total++; if (bus.if_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_rsp_wait got=%b exp=0", bus.if_rsp_valid); end
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hFFFF_FFFF;
        #1;
        total++; if (bus.if_rsp_valid !== 1'b0 || bus.mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL flush_drop got=%b/%b exp=0/1", bus.if_rsp_valid, bus.mem_rsp_ready); end
        tick();
        clear_inputs();
        #1;
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL flush_back_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_rsp_backpressure();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h8000_2004;
        tick();
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hCAFE_F00D;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/cafef00d", c, bus.ls_rsp_valid, bus.ls_rdata); end
            total++; if (bus.mem_rsp_ready !== 1'b0 || dbg_state !== ST_RSP) begin bad++; $display("FAIL bp_stall c=%0d got=%b/%0d exp=0/%0d", c, bus.mem_rsp_ready, dbg_state, ST_RSP); end
            tick();
        end
        bus.ls_rsp_ready = 1'b1;
        #1;
        total++; if (bus.mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus.mem_rsp_ready); end
        tick();
        clear_inputs();
        #1;
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL bp_back_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_starvation();
        int  s;
        logic exp_if;
        s = 0;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0200;
        for (int g = 0; g < 6; g++) begin
            bus.ls_req_valid = 1'b1;
            bus.ls_addr      = 32'h8000_3000 + 32'(g * 4);
            #1;
            exp_if = (s == STARVE_LIMIT);
            total++; if ({bus.if_req_ready, bus.ls_req_ready} !== {exp_if, !exp_if}) begin bad++; $display("FAIL starve_grant g=%0d got=%b%b exp=%b%b", g, bus.if_req_ready, bus.ls_req_ready, exp_if, !exp_if); end
            if (exp_if) s = 0;
            else if (s < STARVE_LIMIT) s = s + 1;
            tick();
            bus.ls_req_valid = 1'b0;
            #1;
            total++; if (dbg_starve !== 3'(s)) begin bad++; $display("FAIL starve_cnt g=%0d got=%0d exp=%0d", g, dbg_starve, s); end
            run_mem(32'h0);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h8000_4000;
        tick();
        clear_inputs();
        #1;
        total++; if (dbg_state !== ST_REQ || dbg_starve === 3'd0) begin bad++; $display("FAIL midrst_setup got=%0d/%0d exp=%0d/nonzero", dbg_state, dbg_starve, ST_REQ); end
        rst = 1'b0;
        tick();
        #1;
        total++; if (dbg_state !== ST_IDLE || dbg_starve !== 3'd0) begin bad++; $display("FAIL midrst_state got=%0d/%0d exp=%0d/0", dbg_state, dbg_starve, ST_IDLE); end
        total++; if ({bus.mem_req_valid, bus.mem_rsp_ready, bus.if_rsp_valid, bus.ls_rsp_valid} !== 4'b0000) begin bad++; $display("FAIL midrst_valids got=%b%b%b%b exp=0000", bus.mem_req_valid, bus.mem_rsp_ready, bus.if_rsp_valid, bus.ls_rsp_valid); end
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0300;
        #1;
        total++; if (bus.if_req_ready !== 1'b1) begin bad++; $display("FAIL midrst_fresh_grant got=%b exp=1", bus.if_req_ready); end
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0300) begin bad++; $display("FAIL midrst_fresh_req got=%b/%h exp=1/80000300", bus.mem_req_valid, bus.mem_addr); end
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0297;
        bus.if_rsp_ready  = 1'b1;
        #1;
        total++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rdata !== 32'h0000_0297) begin bad++; $display("FAIL midrst_fresh_rsp got=%b/%h exp=1/00000297", bus.if_rsp_valid, bus.if_rdata); end
        tick();
        clear_inputs();
    endtask

    // Transaction-level model: choose the winner from the priority rules, queue the
    // expected payload, then track the response routing and fetch-cancel semantics.
    task automatic test_random();
        int   starve_m, stall, dly, n;
        logic ifv, lsv, fl, win_if, win_ls, owner_if_m, drop_m, done, exp_rdy, exp_ifv, exp_lsv;
        logic [W-1:0] pay, exp_pay;
        logic [31:0] rd;
        rst = 1'b0;
        clear_inputs();
        tick();
        rst = 1'b1;
        starve_m = 0;
        for (int t = 0; t < 200; t++) begin
            ifv = ($urandom_range(0, 2) != 0);
            lsv = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 3) == 0);
            bus.if_req_valid = ifv;
            bus.ls_req_valid = lsv;
            bus.if_flush     = fl;
            bus.if_addr      = $urandom;
            bus.ls_addr      = $urandom;
            bus.ls_wen       = 1'($urandom_range(0, 1));
            bus.ls_wdata     = $urandom;
            bus.ls_wstrb     = 4'($urandom_range(0, 15));
            win_if = ifv && !fl && (!lsv || starve_m == STARVE_LIMIT);
            win_ls = lsv && !win_if;
            #1;
            total++; if ({bus.if_req_ready, bus.ls_req_ready} !== {win_if, win_ls}) begin bad++; $display("FAIL rnd_grant t=%0d got=%b%b exp=%b%b", t, bus.if_req_ready, bus.ls_req_ready, win_if, win_ls); end
            if (win_if) begin
                starve_m = 0;
                exp_q.push_back({bus.if_addr, 1'b0, 32'h0, 4'h0});
            end else if (win_ls) begin
                if (ifv && !fl) starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
                else if (!ifv) starve_m = 0;
                exp_q.push_back({bus.ls_addr, bus.ls_wen, bus.ls_wdata, bus.ls_wstrb});
            end
            tick();
            clear_inputs();
            #1;
            total++; if (dbg_starve !== 3'(starve_m)) begin bad++; $display("FAIL rnd_starve t=%0d got=%0d exp=%0d", t, dbg_starve, starve_m); end
            total++; if (bus.mem_req_valid !== (win_if || win_ls)) begin bad++; $display("FAIL rnd_req_valid t=%0d got=%b exp=%b", t, bus.mem_req_valid, win_if || win_ls); end
            if (!(win_if || win_ls)) continue;
            owner_if_m = win_if;
            drop_m     = 1'b0;
            stall      = $urandom_range(0, 3);
            exp_pay    = exp_q.pop_front();
            for (int c = 0; c <= stall; c++) begin
                bus.mem_req_ready = (c == stall);
                bus.if_flush      = ($urandom_range(0, 3) == 0);
                bus.if_req_valid  = 1'($urandom_range(0, 1));
                bus.ls_req_valid  = 1'($urandom_range(0, 1));
                #1;
                pay = {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb};
                total++; if (bus.mem_req_valid !== 1'b1 || pay !== exp_pay) begin bad++; $display("FAIL rnd_req t=%0d got=%b/%h exp=1/%h", t, bus.mem_req_valid, pay, exp_pay); end
                total++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b00) begin bad++; $display("FAIL rnd_req_busy t=%0d got=%b%b exp=00", t, bus.if_req_ready, bus.ls_req_ready); end
                if (bus.if_flush && owner_if_m) drop_m = 1'b1;
                tick();
            end
            clear_inputs();
            dly  = $urandom_range(0, 2);
            done = 1'b0;
            n    = 0;
            while (!done) begin
                rd = $urandom;
                bus.mem_rsp_valid = (n >= dly);
                bus.mem_rdata     = rd;
                bus.if_rsp_ready  = (n >= dly + 3) || ($urandom_range(0, 1) == 1);
                bus.ls_rsp_ready  = (n >= dly + 3) || ($urandom_range(0, 1) == 1);
                bus.if_flush      = ($urandom_range(0, 3) == 0);
                bus.ls_req_valid  = 1'($urandom_range(0, 1));
                #1;
                exp_rdy = drop_m || (owner_if_m ? bus.if_rsp_ready : bus.ls_rsp_ready);
                exp_ifv = bus.mem_rsp_valid && owner_if_m && !drop_m;
                exp_lsv = bus.mem_rsp_valid && !owner_if_m;
                total++; if ({bus.if_rsp_valid, bus.ls_rsp_valid, bus.mem_rsp_ready} !== {exp_ifv, exp_lsv, exp_rdy}) begin bad++; $display("FAIL rnd_rsp t=%0d n=%0d got=%b%b%b exp=%b%b%b", t, n, bus.if_rsp_valid, bus.ls_rsp_valid, bus.mem_rsp_ready, exp_ifv, exp_lsv, exp_rdy); end
                total++; if ({bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid} !== 3'b000) begin bad++; $display("FAIL rnd_rsp_busy t=%0d got=%b%b%b exp=000", t, bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid); end
                if (exp_ifv) begin
                    total++; if (bus.if_rdata !== rd) begin bad++; $display("FAIL rnd_if_rdata t=%0d got=%h exp=%h", t, bus.if_rdata, rd); end
                end
                if (exp_lsv) begin
                    total++; if (bus.ls_rdata !== rd) begin bad++; $display("FAIL rnd_ls_rdata t=%0d got=%h exp=%h", t, bus.ls_rdata, rd); end
                end
                done = bus.mem_rsp_valid && exp_rdy;
                if (bus.if_flush && owner_if_m) drop_m = 1'b1;
                tick();
                n++;
            end
            clear_inputs();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_queue_left got=%0d exp=0", exp_q.size()); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();
        test_reset();
        test_if_alone();
        test_ls_priority();
        test_flush_in_req();
        test_rsp_backpressure();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
